// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the architectural PC, drives a handshaked
// variable-latency instruction-memory port and loads the IF/ID register.
module fetch_unit #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_data,
   input  logic        imem_valid,
   input  logic        stall_id,
   input  logic        branch_taken,
   input  logic [15:0] branch_target,
   output logic [15:0] ifid_instr,
   output logic [15:0] ifid_pc_plus2,
   output logic        ifid_valid,
   output logic        halted,
   output logic [15:0] pc_cur
);

   typedef enum logic [1:0] {S_REQ, S_DROP, S_HOLD, S_HALT} state_t;

   state_t      state, state_d;
   logic [15:0] pc, pc_d;
   logic [15:0] drop_addr, drop_addr_d;
   logic [15:0] buf_instr, buf_instr_d;
   logic [15:0] buf_pc2, buf_pc2_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] pc2_q, pc2_d;
   logic        valid_q, valid_d;
   logic        redir;
   logic [15:0] pc_plus2;

   assign redir    = branch_taken & ~stall_id;
   assign pc_plus2 = pc + 16'd2;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_REQ;
         pc        <= RESET_PC;
         drop_addr <= '0;
         buf_instr <= '0;
         buf_pc2   <= '0;
         instr_q   <= '0;
         pc2_q     <= '0;
         valid_q   <= 1'b0;
      end else begin
         state     <= state_d;
         pc        <= pc_d;
         drop_addr <= drop_addr_d;
         buf_instr <= buf_instr_d;
         buf_pc2   <= buf_pc2_d;
         instr_q   <= instr_d;
         pc2_q     <= pc2_d;
         valid_q   <= valid_d;
      end
   end

   always_comb begin
      state_d     = state;
      pc_d        = pc;
      drop_addr_d = drop_addr;
      buf_instr_d = buf_instr;
      buf_pc2_d   = buf_pc2;
      instr_d     = instr_q;
      pc2_d       = pc2_q;
      valid_d     = valid_q;

      imem_req  = ~rst & ((state == S_REQ) | (state == S_DROP));
      imem_addr = (state == S_DROP) ? drop_addr : pc;
      halted    = (state == S_HALT);

      if (redir) begin
         // An unanswered request must still be drained at its original
         // address, so REQ without a response parks the address in DROP.
         valid_d = 1'b0;
         pc_d    = {branch_target[15:1], 1'b0};
         case (state)
            S_REQ: begin
               if (!imem_valid) begin
                  drop_addr_d = pc;
                  state_d     = S_DROP;
               end
            end
            S_DROP:  state_d = S_DROP;
            default: state_d = S_REQ;
         endcase
      end else begin
         case (state)
            S_REQ: begin
               if (imem_valid) begin
                  if (!stall_id) begin
                     instr_d = imem_data;
                     pc2_d   = pc_plus2;
                     valid_d = 1'b1;
                     if (imem_data[15:12] == HALT_OPCODE) begin
                        state_d = S_HALT;
                     end else begin
                        pc_d = pc_plus2;
                     end
                  end else begin
                     buf_instr_d = imem_data;
                     buf_pc2_d   = pc_plus2;
                     if (imem_data[15:12] != HALT_OPCODE) begin
                        pc_d = pc_plus2;
                     end
                     state_d = S_HOLD;
                  end
               end else if (!stall_id) begin
                  valid_d = 1'b0;
               end
            end
            S_DROP: begin
               if (!stall_id) begin
                  valid_d = 1'b0;
               end
               if (imem_valid) begin
                  state_d = S_REQ;
               end
            end
            S_HOLD: begin
               if (!stall_id) begin
                  instr_d = buf_instr;
                  pc2_d   = buf_pc2;
                  valid_d = 1'b1;
                  state_d = (buf_instr[15:12] == HALT_OPCODE) ? S_HALT : S_REQ;
               end
            end
            default: state_d = S_HALT;
         endcase
      end
   end

   assign ifid_instr    = instr_q;
   assign ifid_pc_plus2 = pc2_q;
   assign ifid_valid    = valid_q;
   assign pc_cur        = pc;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decode-stage branch/PC control logic.
- Holds the architectural PC and drives a handshaked instruction-memory port; instruction-memory latency is variable, 0..N cycles.
- Loads the IF/ID pipeline register with {instruction, PC+2, valid}. Decode consumes PC+2 as its branch base and returns branch_taken/branch_target.
- Also handles decode stalls, flushes on taken branches, and halt detection.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HALT_OPCODE, 4'hF, instr[15:12] value that stops fetching.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request; imem_addr is valid while high.
- imem_addr  output  16  fetch address; stable while imem_req=1 and imem_valid=0.
- imem_data  input  16  instruction word; sampled only when imem_valid=1.
- imem_valid  input  1  response strobe; may assert in the same cycle as imem_req.
- stall_id  input  1  decode hazard stall; IF/ID must hold.
- branch_taken  input  1  redirect request from decode.
- branch_target  input  16  redirect PC from decode.
- ifid_instr  output  16  IF/ID instruction.
- ifid_pc_plus2  output  16  IF/ID fetch address + 2.
- ifid_valid  output  1  IF/ID entry valid; 0 means bubble.
- halted  output  1  high while the FSM is in HALT.
- pc_cur  output  16  current PC register.

Behaviour:
- Reset (rst=1 at clock edge):
  - pc<=RESET_PC, state<=REQ.
  - ifid_instr, ifid_pc_plus2, ifid_valid <= 0; halted=0.
  - imem_req is forced to 0 while rst=1.
  - The first request issues in the first cycle after rst deasserts.
  - rst mid-request abandons the request; the memory is reset alongside this block.
- States: REQ, DROP, HOLD, HALT.
- imem_req is 1 in REQ and DROP, 0 otherwise.
- imem_addr = pc in REQ, and the latched drop_addr in DROP.
- Redirect condition: redir = branch_taken & ~stall_id. branch_taken is ignored while stall_id=1.
- Redirect, from any state (priority over all other transitions):
  - ifid_valid<=0, which flushes the wrong-path instruction.
  - pc<={branch_target[15:1],1'b0}, forcing alignment.
  - From REQ with imem_valid=1: discard the response, stay REQ.
  - From REQ with imem_valid=0: drop_addr<=pc, go DROP.
  - From DROP: stay DROP; pc updated.
  - From HOLD: discard the buffer, go REQ.
  - From HALT: go REQ.
- REQ, imem_valid=1, stall_id=0:
  - ifid_instr<=imem_data, ifid_pc_plus2<=pc+2, ifid_valid<=1.
  - If imem_data[15:12]==HALT_OPCODE: pc holds, go HALT.
  - Else pc<=pc+2, stay REQ.
  - Steady-state throughput: 1 instruction/cycle on same-cycle hits.
- REQ, imem_valid=1, stall_id=1:
  - IF/ID holds; buf_instr<=imem_data, buf_pc2<=pc+2.
  - pc<=pc+2 unless the buffered word is a halt.
  - Go HOLD.
- REQ, imem_valid=0:
  - stall_id=1: IF/ID holds.
  - stall_id=0: ifid_valid<=0 (bubble).
  - Stay REQ.
- DROP:
  - On imem_valid: discard the data, go REQ.
  - IF/ID holds if stall_id=1, else ifid_valid<=0.
- HOLD:
  - When stall_id=0: IF/ID<={buf_instr, buf_pc2, 1}.
  - Go HALT if the buffered opcode==HALT_OPCODE, else REQ.
  - While stall_id=1: no request is issued.
- HALT:
  - No requests; IF/ID holds its contents; halted=1.
  - Exit only by redirect or rst.
- Arithmetic: 16-bit PC+2 wraps modulo 2^16 (16'hFFFE+2 = 16'h0000). No overflow flag.
- Invariants:
  - At most one outstanding request.
  - A response is never accepted twice.
  - imem_addr never changes while a request is unanswered.

Test Plan:
- Reset then same-cycle hits, stall_id=0, memory returns 0x1111/0x2222/0x3333 at 0,2,4 -> imem_addr 0,2,4 on consecutive cycles; ifid_pc_plus2 2,4,6; ifid_valid=1 every cycle from the second post-reset cycle.
- 3-cycle memory latency -> imem_addr=0 held stable 3 cycles; ifid_valid=0 bubbles in the waiting cycles; one instruction latched per response.
- Data arrives with stall_id=1 for 2 cycles -> IF/ID unchanged during the stall; buffered word appears the cycle stall_id drops; no duplicate and no lost instruction.
- branch_taken=1, target 0x0041, while a 3-cycle fetch to 0x0008 is outstanding -> ifid_valid=0 next cycle; 0x0008 response discarded; next imem_addr=0x0040.
- HALT opcode (0xF000) fetched at 0x0010 -> ifid_valid=1 with 0xF000; halted=1; imem_req=0 for 10+ cycles; then branch_taken to 0x0020 -> halted=0, imem_addr=0x0020.
- PC=0xFFFE, no branch -> next imem_addr 0x0000; branch_taken asserted with stall_id=1 -> ignored, pc unchanged.
